// File: rtl/sine_nco_pkg.sv
// Shared constants, quadrant type and quarter-wave sine table for the NCO.
// Table entry i holds round(127*sin(pi*(2i+1)/256)); it never contains 0.
package sine_nco_pkg;

  localparam int NCO_PHASE_W    = 16;
  localparam int NCO_LUT_ADDR_W = 6;
  localparam int NCO_AMP_W      = 8;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  localparam logic [6:0] QUARTER_ROM [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  // Quadrants 1 and 3 walk the quarter table backwards.
  function automatic logic mirror_index(input quadrant_e q);
    return (q == Q1) || (q == Q3);
  endfunction

  function automatic logic negate_half(input quadrant_e q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave magnitude ROM: address in, magnitude out one cycle later.
module sine_quarter_lut
  import sine_nco_pkg::*;
#(
  parameter int ADDR_W = NCO_LUT_ADDR_W,
  parameter int MAG_W  = NCO_AMP_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_q;

  always_comb begin
    mag_d = QUARTER_ROM[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/sine_nco_gen.sv
// Phase-accumulator sine NCO: quadrant-folded quarter ROM, two-stage output pipe.
// sample_valid is a one-cycle strobe per sample; there is no back-pressure.
module sine_nco_gen
  import sine_nco_pkg::*;
#(
  parameter int PHASE_W    = NCO_PHASE_W,
  parameter int LUT_ADDR_W = NCO_LUT_ADDR_W,
  parameter int AMP_W      = NCO_AMP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sync_clr,
  input  logic               freq_load,
  input  logic [PHASE_W-1:0] freq_word,
  output logic [AMP_W-1:0]   sine_wave,
  output logic               sample_valid,
  output logic               phase_wrap
);

  logic [PHASE_W-1:0]    acc_d, acc_q;
  logic [PHASE_W-1:0]    freq_d, freq_q;
  logic                  wrap_d, wrap_q;
  logic [PHASE_W:0]      acc_sum;

  quadrant_e             quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [LUT_ADDR_W-1:0] lut_addr;
  logic [AMP_W-2:0]      lut_mag;

  logic                  v1_d, v1_q;
  logic                  neg1_d, neg1_q;
  logic                  wrap1_d, wrap1_q;
  logic [AMP_W-1:0]      sine_d, sine_q;
  logic                  valid_d, valid_q;
  logic                  pwrap_d, pwrap_q;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, freq_q};
  assign quad     = quadrant_e'(acc_q[PHASE_W-1 -: 2]);
  assign idx      = acc_q[PHASE_W-3 -: LUT_ADDR_W];
  assign lut_addr = mirror_index(quad) ? ~idx : idx;

  // The add always uses the increment held before this edge, so a load
  // coinciding with an update only affects the following update.
  always_comb begin
    acc_d  = acc_q;
    wrap_d = wrap_q;
    freq_d = freq_q;
    if (freq_load) begin
      freq_d = freq_word;
    end
    if (sync_clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end else if (enable) begin
      acc_d  = acc_sum[PHASE_W-1:0];
      wrap_d = acc_sum[PHASE_W];
    end
  end

  always_comb begin
    v1_d    = enable;
    neg1_d  = negate_half(quad);
    wrap1_d = enable & wrap_q;
    valid_d = v1_q;
    pwrap_d = v1_q & wrap1_q;
    sine_d  = sine_q;
    if (v1_q) begin
      sine_d = neg1_q ? -{1'b0, lut_mag} : {1'b0, lut_mag};
    end
  end

  sine_quarter_lut #(
    .ADDR_W (LUT_ADDR_W),
    .MAG_W  (AMP_W - 1)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (lut_addr),
    .mag   (lut_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      freq_q  <= '0;
      wrap_q  <= 1'b0;
      v1_q    <= 1'b0;
      neg1_q  <= 1'b0;
      wrap1_q <= 1'b0;
      sine_q  <= '0;
      valid_q <= 1'b0;
      pwrap_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      wrap_q  <= wrap_d;
      v1_q    <= v1_d;
      neg1_q  <= neg1_d;
      wrap1_q <= wrap1_d;
      sine_q  <= sine_d;
      valid_q <= valid_d;
      pwrap_q <= pwrap_d;
    end
  end

  assign sine_wave    = sine_q;
  assign sample_valid = valid_q;
  assign phase_wrap   = pwrap_q;

endmodule

// File: tb/tb_sine_nco_gen.sv
// Self-checking bench for sine_nco_gen: per-cycle reference model plus directed checks.
module tb_sine_nco_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sync_clr;
  logic        freq_load;
  logic [15:0] freq_word;
  logic [7:0]  sine_wave;
  logic        sample_valid;
  logic        phase_wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  sine_nco_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sync_clr     (sync_clr),
    .freq_load    (freq_load),
    .freq_word    (freq_word),
    .sine_wave    (sine_wave),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Full-period sine sampled at 256 points, taken from the top 8 phase bits.
  function automatic logic [7:0] model_sine(input logic [15:0] phase);
    int  k;
    int  v;
    real r;
    k = int'(phase[15:8]);
    r = 127.0 * $sin(3.14159265358979 * real'(2 * k + 1) / 256.0);
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(-r + 0.5);
    return 8'(v);
  endfunction

  // ---------------- reference model ----------------
  logic [8:0]  exp_q[$];
  int          m_acc;
  int          m_freq;
  logic        m_wrap;
  logic        e_valid;
  logic [7:0]  e_val;
  logic        e_wrap;

  initial begin
    int         sum;
    logic [8:0] tmp;
    m_acc = 0; m_freq = 0; m_wrap = 1'b0;
    e_valid = 1'b0; e_val = 8'h00; e_wrap = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_acc = 0; m_freq = 0; m_wrap = 1'b0;
        exp_q.delete();
        e_valid = 1'b0; e_val = 8'h00; e_wrap = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          tmp = exp_q.pop_front();
          e_valid = 1'b1;
          e_val   = tmp[7:0];
          e_wrap  = tmp[8];
        end else begin
          e_valid = 1'b0;
          e_wrap  = 1'b0;
        end
        if (enable) exp_q.push_back({m_wrap, model_sine(16'(m_acc))});
        sum = m_acc + m_freq;
        if (sync_clr) begin
          m_acc = 0; m_wrap = 1'b0;
        end else if (enable) begin
          m_acc  = sum % 65536;
          m_wrap = (sum >= 65536);
        end
        if (freq_load) m_freq = int'(freq_word);
      end
    end
  end

  // ---------------- compare + sample capture ----------------
  logic [7:0] rec  [0:1023];
  logic       recw [0:1023];
  int         rec_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_valid", 32'(sample_valid), 32'(e_valid));
      check("cyc_sine",  32'(sine_wave),    32'(e_val));
      check("cyc_wrap",  32'(phase_wrap),   32'(e_wrap));
      if (rst_n && sample_valid && rec_n < 1024) begin
        rec[rec_n]  = sine_wave;
        recw[rec_n] = phase_wrap;
        rec_n++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_samples(input int target);
    int budget;
    budget = 2000;
    while (rec_n < target && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("wait_samples", 32'(rec_n >= target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         r0;
    int         bad;
    int         pos;
    logic [7:0] frozen;
    logic [7:0] rect;
    logic [7:0] rexp;

    rst_n = 1'b0; enable = 1'b1; sync_clr = 1'b0; freq_load = 1'b0; freq_word = 16'h0000;

    repeat (3) @(negedge clk);
    check("reset_sine",  32'(sine_wave),    32'd0);
    check("reset_valid", 32'(sample_valid), 32'd0);
    check("reset_wrap",  32'(phase_wrap),   32'd0);

    enable = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    freq_load = 1'b1; freq_word = 16'h0400;
    @(negedge clk);
    freq_load = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("valid_lat1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("valid_lat2", 32'(sample_valid), 32'd1);

    // enable gap mid-period
    wait_samples(100);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      #1;
      frozen = model_sine(16'((rec_n - 1) * 1024));
      check("gap_valid", 32'(sample_valid), 32'd0);
      check("gap_sine",  32'(sine_wave),    32'(frozen));
      check("gap_wrap",  32'(phase_wrap),   32'd0);
    end
    enable = 1'b1;
    wait_samples(140);

    // quadrant points and wrap positions
    check("s0",    32'(rec[0]),  32'h02);
    check("s15",   32'(rec[15]), 32'h7F);
    check("s16",   32'(rec[16]), 32'h7F);
    check("s32",   32'(rec[32]), 32'hFE);
    check("s48",   32'(rec[48]), 32'h81);
    check("s64",   32'(rec[64]), 32'h02);
    check("w63",   32'(recw[63]),  32'd0);
    check("w64",   32'(recw[64]),  32'd1);
    check("w128",  32'(recw[128]), 32'd1);
    bad = 0;
    for (int j = 0; j < 140; j++) begin
      if (rec[j] !== model_sine(16'(j * 1024))) bad++;
      if (recw[j] !== ((j > 0) && (j % 64 == 0))) bad++;
    end
    check("sequence_0400", 32'(bad), 32'd0);

    // rectifier view of one period
    bad = 0; pos = 0;
    for (int j = 0; j < 64; j++) begin
      rect = rec[j][7] ? 8'h00 : rec[j];
      rexp = (j < 32) ? model_sine(16'(j * 1024)) : 8'h00;
      if (rect !== rexp) bad++;
      if (rect != 8'h00) pos++;
    end
    check("rectify_period", 32'(bad), 32'd0);
    check("rectify_pos",    32'(pos), 32'd32);

    // frequency change mid-run
    @(negedge clk);
    freq_load = 1'b1; freq_word = 16'h0800;
    @(negedge clk);
    freq_load = 1'b0;
    repeat (20) @(negedge clk);

    // sync_clr together with enable
    @(negedge clk);
    #1;
    r0 = rec_n;
    sync_clr = 1'b1;
    @(negedge clk);
    #1;
    sync_clr = 1'b0;
    wait_samples(r0 + 4);
    check("clr_phase0", 32'(rec[r0 + 2]),  32'h02);
    check("clr_wrap",   32'(recw[r0 + 2]), 32'd0);
    check("clr_next",   32'(rec[r0 + 3]),  32'h1A);

    // zero increment: constant samples, no wrap
    @(negedge clk);
    #1;
    freq_load = 1'b1; freq_word = 16'h0000; sync_clr = 1'b1;
    @(negedge clk);
    #1;
    freq_load = 1'b0; sync_clr = 1'b0;
    wait_samples(rec_n + 8);
    check("zero_freq_val",  32'(rec[rec_n - 1]),  32'h02);
    check("zero_freq_wrap", 32'(recw[rec_n - 1]), 32'd0);

    // asynchronous reset mid-run
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sine",  32'(sine_wave),    32'd0);
    check("async_valid", 32'(sample_valid), 32'd0);
    check("async_wrap",  32'(phase_wrap),   32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
